qos_deq_scheduler: RTL and testbench

Dequeue scheduler for the QoS queue set. It watches the depth reported by each queue's pointer control unit and picks one non-empty queue per dequeue slot, using either strict priority or weighted round-robin (WRR). It then drives that queue's single-cycle dequeue request (the queue's read-enable input) under a valid/ready handshake with the downstream output port. It sits between the per-queue pointer control units and the output-port logic.

---
 rtl/qos_deq_scheduler.sv | 155 +++++++++++++++
 tb/tb_qos_deq_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/qos_deq_scheduler.sv
// Dequeue scheduler for the QoS queue set: picks one non-empty queue per slot
// (strict priority or weighted round-robin) and strobes its read enable.
module qos_deq_scheduler #(
    parameter int NUM_Q    = 4,
    parameter int DEPTH_W  = 3,
    parameter int WEIGHT_W = 4,
    parameter int QID_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_Q*DEPTH_W-1:0]    q_depth,
    input  logic [NUM_Q*WEIGHT_W-1:0]   q_weight,
    input  logic                        sp_mode,
    input  logic                        cfg_load,
    input  logic                        out_ready,
    output logic [NUM_Q-1:0]            deq_en,
    output logic                        deq_valid,
    output logic [QID_W-1:0]            deq_qid,
    output logic [1:0]                  sched_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [QID_W-1:0]       qid_reg;
    logic [QID_W-1:0]       last_grant_reg;
    logic                   wrr_grant_reg;
    logic [WEIGHT_W-1:0]    credit_reg [NUM_Q];

    logic [WEIGHT_W-1:0]    eff_w [NUM_Q];
    logic [NUM_Q-1:0]       eligible;
    logic [NUM_Q-1:0]       has_credit;
    logic                   any_eligible;
    logic [QID_W-1:0]       sp_qid;
    logic [QID_W-1:0]       wrr_qid;
    logic                   wrr_found;
    logic                   handshake;
    logic                   reload_all;

    generate
        for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_queue
            logic [WEIGHT_W-1:0] raw_w;
            assign raw_w         = q_weight[gi*WEIGHT_W +: WEIGHT_W];
            assign eff_w[gi]     = (raw_w == '0) ? WEIGHT_W'(1) : raw_w;
            assign eligible[gi]  = (q_depth[gi*DEPTH_W +: DEPTH_W] != '0);
            assign has_credit[gi] = eligible[gi] && (credit_reg[gi] != '0);
        end
    endgenerate

    assign any_eligible = |eligible;
    assign wrr_found    = |has_credit;
    assign handshake    = (state_reg == ISSUE) && out_ready;

    // Lowest-index eligible queue wins; the descending loop lets lower indices overwrite.
    always_comb begin
        sp_qid = '0;
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sp_qid = QID_W'(i);
            end
        end
    end

    // Cyclic search starting just after the last grant; nearest candidate overwrites last.
    always_comb begin
        int idx;
        logic [QID_W-1:0] idx_q;
        idx     = 0;
        idx_q   = '0;
        wrr_qid = '0;
        for (int k = NUM_Q - 1; k >= 0; k--) begin
            idx   = (int'(last_grant_reg) + 1 + k) % NUM_Q;
            idx_q = QID_W'(idx);
            if (has_credit[idx_q]) begin
                wrr_qid = idx_q;
            end
        end
    end

    // Credits refill when every eligible queue has run dry, or on an explicit load.
    assign reload_all = cfg_load ||
                        ((state_reg == SELECT) && any_eligible && !sp_mode && !wrr_found);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            qid_reg        <= '0;
            last_grant_reg <= QID_W'(NUM_Q - 1);
            wrr_grant_reg  <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (any_eligible) begin
                        state_reg <= SELECT;
                    end
                end
                SELECT: begin
                    if (!any_eligible) begin
                        state_reg <= IDLE;
                    end else if (sp_mode) begin
                        qid_reg       <= sp_qid;
                        wrr_grant_reg <= 1'b0;
                        state_reg     <= ISSUE;
                    end else if (wrr_found) begin
                        qid_reg       <= wrr_qid;
                        wrr_grant_reg <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (out_ready) begin
                        last_grant_reg <= qid_reg;
                        state_reg      <= HOLD;
                    end
                end
                HOLD: begin
                    state_reg <= any_eligible ? SELECT : IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_credit
            logic dec;
            assign dec = handshake && wrr_grant_reg && (qid_reg == QID_W'(gi));
            always_ff @(posedge clk) begin
                if (!rst || reload_all) begin
                    credit_reg[gi] <= eff_w[gi];
                end else if (dec && (credit_reg[gi] != '0)) begin
                    credit_reg[gi] <= credit_reg[gi] - WEIGHT_W'(1);
                end
            end
        end
    endgenerate

    // Gated with rst so a reset landing on a handshake cycle never strobes a queue.
    always_comb begin
        deq_en = '0;
        if (handshake && rst) begin
            deq_en[qid_reg] = 1'b1;
        end
    end

    assign deq_valid   = (state_reg == ISSUE);
    assign deq_qid     = qid_reg;
    assign sched_state = state_reg;

endmodule

// File: tb/tb_qos_deq_scheduler.sv
// Directed bench for qos_deq_scheduler: grant expectations go into a scoreboard
// and a monitor branch checks every deq_en pulse against it.
module tb_qos_deq_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] q_depth;
    logic [15:0] q_weight;
    logic        sp_mode;
    logic        cfg_load;
    logic        out_ready;
    logic [3:0]  deq_en;
    logic        deq_valid;
    logic [1:0]  deq_qid;
    logic [1:0]  sched_state;

    qos_deq_scheduler #(.NUM_Q(4), .DEPTH_W(3), .WEIGHT_W(4), .QID_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .q_depth     (q_depth),
        .q_weight    (q_weight),
        .sp_mode     (sp_mode),
        .cfg_load    (cfg_load),
        .out_ready   (out_ready),
        .deq_en      (deq_en),
        .deq_valid   (deq_valid),
        .deq_qid     (deq_qid),
        .sched_state (sched_state)
    );

    always #5 clk = ~clk;

    // Queue occupancy model: loads a new depth set on request, else drains on deq_en.
    logic [2:0] dep [4];
    int         load_vals [4];
    int         load_seq  = 0;
    int         load_seen = 0;

    always @(posedge clk) begin
        if (load_seq != load_seen) begin
            for (int i = 0; i < 4; i++) dep[i] <= 3'(load_vals[i]);
            load_seen <= load_seq;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (deq_en[i] && dep[i] != 3'd0) dep[i] <= dep[i] - 3'd1;
            end
        end
    end

    always_comb begin
        q_depth = '0;
        for (int i = 0; i < 4; i++) q_depth[i*3 +: 3] = dep[i];
    end

    typedef struct {
        int qid;
        int gap;
    } exp_t;

    exp_t exp_q [$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   cyc       = 0;
    int   last_pulse = 0;

    task automatic chk(input string name, input int act, input int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    endtask

    task automatic push(input int qid, input int gap);
        exp_t e;
        e.qid = qid;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic set_depths(input int d0, input int d1, input int d2, input int d3);
        load_vals[0] = d0; load_vals[1] = d1; load_vals[2] = d2; load_vals[3] = d3;
        load_seq++;
    endtask

    task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
        q_weight = {4'(w3), 4'(w2), 4'(w1), 4'(w0)};
    endtask

    task automatic begin_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic end_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk(name, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wait_valid_qid(input string name, input int qid, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(deq_valid && int'(deq_qid) == qid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(deq_valid && int'(deq_qid) == qid)) chk(name, int'(deq_valid), 1);
    endtask

    initial begin
        rst = 1'b0; sp_mode = 1'b1; cfg_load = 1'b0; out_ready = 1'b0;
        set_weights(1, 1, 1, 1);
        set_depths(2, 3, 0, 1);
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    cyc++;
                    if (deq_en != 4'd0) begin
                        chk("grant_onehot", $countones(deq_en), 1);
                        chk("grant_handshake", int'({deq_valid, out_ready}), 3);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_grant", exp_q.size(), 1);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            $display("grant qid=%0d exp=%0d strobe=%b cycle=%0d", deq_qid, e.qid, deq_en, cyc);
                            chk("grant_qid", int'(deq_qid), e.qid);
                            chk("grant_strobe", int'(deq_en), 1 << e.qid);
                            if (e.gap > 0) chk("grant_gap", cyc - last_pulse, e.gap);
                        end
                        last_pulse = cyc;
                    end
                end
            end
            begin : stimulus
                // Reset held with traffic pending, then release and time the first grant.
                out_ready = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_valid", int'(deq_valid), 0);
                    chk("rst_en", int'(deq_en), 0);
                    chk("rst_state", int'(sched_state), 0);
                end
                push(0, 0); push(0, 3); push(1, 3); push(1, 3); push(1, 3); push(3, 3);
                @(posedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("lat_cycle1_valid", int'(deq_valid), 0);
                chk("lat_cycle1_state", int'(sched_state), 1);
                @(negedge clk);
                chk("lat_cycle2_valid", int'(deq_valid), 1);
                wait_drain("sp_drain_timeout", 100);
                repeat (6) @(negedge clk);
                chk("sp_idle_state", int'(sched_state), 0);
                chk("sp_idle_valid", int'(deq_valid), 0);

                // WRR with a zero weight and one credit-reload slot.
                begin_reset();
                set_depths(7, 7, 7, 7); set_weights(3, 1, 2, 0); sp_mode = 1'b0; out_ready = 1'b1;
                push(0, 0); push(1, 3); push(2, 3); push(3, 3); push(0, 3); push(2, 3); push(0, 3); push(1, 4);
                end_reset();
                wait_drain("wrr_drain_timeout", 100);

                // Backpressure on a pending q2 grant.
                begin_reset();
                set_depths(0, 0, 1, 0); sp_mode = 1'b1; out_ready = 1'b0;
                end_reset();
                wait_valid_qid("bp_valid_timeout", 2, 20);
                sp_mode = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_valid", int'(deq_valid), 1);
                    chk("bp_qid", int'(deq_qid), 2);
                    chk("bp_en", int'(deq_en), 0);
                end
                push(2, 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
                wait_drain("bp_drain_timeout", 20);

                // Only q3 eligible: search from q0 wraps round to q3.
                begin_reset();
                set_depths(0, 0, 0, 1); set_weights(1, 1, 1, 1); sp_mode = 1'b0; out_ready = 1'b1;
                push(3, 0);
                end_reset();
                wait_drain("wrap_drain_timeout", 30);
                repeat (5) @(negedge clk);
                chk("wrap_idle_state", int'(sched_state), 0);

                // cfg_load on the first q1 handshake restores credit[1]=2.
                begin_reset();
                set_depths(7, 7, 7, 7); set_weights(1, 2, 1, 1); sp_mode = 1'b0; out_ready = 1'b1;
                push(0, 0); push(1, 3); push(2, 3); push(3, 3); push(0, 3); push(1, 3); push(1, 3);
                end_reset();
                wait_valid_qid("cfg_valid_timeout", 1, 30);
                cfg_load = 1'b1;
                @(posedge clk);
                #1 cfg_load = 1'b0;
                wait_drain("cfg_drain_timeout", 100);

                // Reset arriving on a handshake cycle suppresses the strobe.
                begin_reset();
                set_depths(7, 7, 7, 7); set_weights(2, 1, 1, 1); sp_mode = 1'b0; out_ready = 1'b0;
                end_reset();
                wait_valid_qid("midrst_valid_timeout", 0, 20);
                @(posedge clk);
                #1 rst = 1'b0; out_ready = 1'b1;
                @(negedge clk);
                chk("midrst_state_issue", int'(sched_state), 2);
                chk("midrst_en", int'(deq_en), 0);
                @(posedge clk);
                push(0, 0); push(1, 3); push(2, 3); push(3, 3); push(0, 3); push(1, 4);
                end_reset();
                wait_drain("midrst_drain_timeout", 100);
                begin_reset();
                repeat (3) @(negedge clk);

                $display("%0d/%0d checks passed", pass_cnt, total_cnt);
                $finish;
            end
        join_any
    end

endmodule
